window_gen_kxk: RTL
===================

Name: window_gen_kxk

Overview:
Parametrised successor of the 3x3 padding/window stage. It turns a raster stream of multi-channel pixels into KxK sliding windows, with:
- configurable zero padding and stride;
- full ready/valid backpressure on both sides;
- internally generated end-of-frame flush, so the block does not rely on i_tlast for framing.

It sits between the input pixel FIFO and the convolution array.

Parameters:
- NUM_CHANNELS, 8, channels per pixel word.
- DATA_WIDTH, 8, bits per channel sample.
- MAX_IMG_WIDTH, 1024, largest supported image width; sizes the line buffers.
- FILTER_SIZE, 3, window side K; odd, 3..7.
- PAD, FILTER_SIZE/2, border width applied when padding is enabled.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_cfg_width  in  16  image width W; values above MAX_IMG_WIDTH are clamped to MAX_IMG_WIDTH.
- i_cfg_height  in  16  image height H.
- i_cfg_pad_en  in  1  1 = zero-pad by PAD on all sides ("same" output); 0 = "valid" windows only.
- i_cfg_stride  in  2  window stride S; value 0 is treated as 1; values 1..3 are legal.
- i_valid  in  1  input pixel valid.
- i_data  in  NUM_CHANNELS*DATA_WIDTH  input pixel.
- i_tlast  in  1  upstream end-of-frame marker; checked only, never used for framing.
- o_ready  out  1  block can accept an input pixel.
- o_valid  out  1  window valid.
- o_windows  out  K*K*NUM_CHANNELS*DATA_WIDTH  window, element (r,c) at slice index r*K+c; r=0 is the top row, c=0 the left column.
- o_tlast  out  1  high with the last window of the frame.
- i_ready  in  1  downstream accepts the window.
- o_busy  out  1  a frame is in progress.
- o_err  out  1  sticky i_tlast mismatch flag; cleared only by rst.

Behaviour:
- Reset values: o_valid=0, o_tlast=0, o_ready=0, o_busy=0, o_err=0, o_windows=0. FSM returns to IDLE; all counters cleared. Line-buffer contents are don't-care.
- Config capture: W, H, pad_en and S are latched on the IDLE->RUN transition. Changes during a frame are ignored.
- Scan grid: Wp=W+2*PAD, Hp=H+2*PAD when padding is enabled; Wp=W, Hp=H otherwise. Counters x (0..Wp-1) and y (0..Hp-1).
  - Positions inside the image consume one input pixel.
  - Pad positions inject 0 and consume nothing.
- Line buffers: K-1 buffers of depth MAX_IMG_WIDTH+2*PAD plus a KxK shift register.
- Window emission: a window is emitted for a scan position (x,y) when all of the following hold:
  - x>=K-1 and y>=K-1;
  - (x-(K-1)) mod S == 0;
  - (y-(K-1)) mod S == 0.
- Window counts:
  - pad on: ceil(W/S)*ceil(H/S) windows;
  - pad off: ((W-K)/S+1)*((H-K)/S+1) windows.
- FSM states:
  - IDLE: o_ready=1. First accepted i_valid -> RUN; o_busy goes high the same cycle.
  - RUN: the scan advances one position per cycle when both hold: (position is pad, or i_valid&&o_ready) and the output slot is free or being drained (!o_valid || i_ready). When the last image pixel is consumed -> FLUSH.
  - FLUSH: o_ready=0. Remaining pad positions (bottom and right borders) are scanned under the same output-slot rule. After the final scan position -> DRAIN.
  - DRAIN: wait until the last window has been accepted (o_valid&&o_tlast&&i_ready), then -> IDLE; o_busy drops the next cycle.
- o_ready in RUN: high only when the current position is an image position and the output slot can advance. No input is accepted during pad positions.
- Latency: 2 cycles from the scan step that completes a window to o_valid.
- Output hold: o_valid/o_windows/o_tlast are held stable while i_ready=0. There is no window loss and no duplication.
- Degenerate config: with pad off and W<K or H<K, the frame is still consumed (W*H pixels), zero windows are emitted, and o_err is set.
- i_tlast check: o_err sets if i_tlast=1 on any pixel other than pixel W*H, or is 0 on pixel W*H.
- Simultaneous events: frame-end DRAIN->IDLE and a new i_valid in the same cycle; the pixel is not accepted (o_ready=0 in DRAIN) and is taken next cycle.
- rst mid-frame: immediate abort, outputs take reset values, partial window discarded.

Optional Feature:
- WINGEN_PAD_VALUE_EN:
  - When defined, adds input i_cfg_pad_value [NUM_CHANNELS*DATA_WIDTH-1:0], latched with the other config; pad positions inject this value instead of 0.
  - When undefined, the port is absent and pad positions inject 0.

Test Plan:
1. K=3, W=H=4, pad on, S=1, pixel(r,c)=r*4+c+1 -> 16 windows; first window = [0,0,0, 0,1,2, 0,5,6]; last window = [11,12,0, 15,16,0, 0,0,0] with o_tlast=1; o_err=0.
2. Same image, pad off -> 4 windows; first = [1,2,3, 5,6,7, 9,10,11]; last = [6,7,8, 10,11,12, 14,15,16].
3. W=H=5, pad on, S=2 -> 9 windows centred on (0,0),(0,2),(0,4),...,(4,4); o_tlast on the 9th only.
4. Case 1 with i_ready low for 10 cycles after window 3 -> window 4 held bit-stable; all 16 windows delivered in order; o_ready low while the slot is full.
5. i_tlast asserted on pixel 10 of 16 -> o_err=1 and stays 1; 16 windows still emitted; a rst pulse mid-frame returns all outputs to reset values within 0 cycles (asynchronous).
6. With WINGEN_PAD_VALUE_EN defined and pad value 0xAA in every channel, case 1 -> first window = [AA,AA,AA, AA,1,2, AA,5,6].

Source files
------------

// File: rtl/window_gen_kxk.sv
// window_gen_kxk: turns a raster pixel stream into KxK sliding windows with padding, stride and backpressure.
// Optional macro WINGEN_PAD_VALUE_EN adds i_cfg_pad_value, injected at pad positions instead of zero.
module window_gen_kxk #(
  parameter int unsigned NUM_CHANNELS  = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned MAX_IMG_WIDTH = 1024,
  parameter int unsigned FILTER_SIZE   = 3,
  parameter int unsigned PAD           = FILTER_SIZE / 2
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic [15:0]                                                i_cfg_width,
  input  logic [15:0]                                                i_cfg_height,
  input  logic                                                       i_cfg_pad_en,
  input  logic [1:0]                                                 i_cfg_stride,
`ifdef WINGEN_PAD_VALUE_EN
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]                         i_cfg_pad_value,
`endif
  input  logic                                                       i_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]                         i_data,
  input  logic                                                       i_tlast,
  output logic                                                       o_ready,
  output logic                                                       o_valid,
  output logic [FILTER_SIZE*FILTER_SIZE*NUM_CHANNELS*DATA_WIDTH-1:0] o_windows,
  output logic                                                       o_tlast,
  input  logic                                                       i_ready,
  output logic                                                       o_busy,
  output logic                                                       o_err
);

  localparam int unsigned K        = FILTER_SIZE;
  localparam int unsigned PW       = NUM_CHANNELS * DATA_WIDTH;
  localparam int unsigned WW       = K * K * PW;
  localparam int unsigned LB_DEPTH = MAX_IMG_WIDTH + 2 * PAD;
  localparam int unsigned XW       = $clog2(LB_DEPTH);
  localparam int unsigned YW       = 18;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic          ready_c, step_c, capture_c;

  logic [15:0]   cfg_w_c;
  logic [XW-1:0] x_lo_c, x_hi_c, x_max_c;
  logic [YW-1:0] y_lo_c, y_hi_c, y_max_c;
  logic [31:0]   total_c;
  logic          degen_c;
  logic [1:0]    stride_c;

  logic [1:0]    stride_q;
  logic [XW-1:0] x_lo_q, x_hi_q, x_max_q, x_q;
  logic [YW-1:0] y_lo_q, y_hi_q, y_max_q, y_q;
  logic [1:0]    x_ph_q, y_ph_q;
  logic [31:0]   total_q, pix_cnt_q;
  logic          degen_q, first_vld_q, last_done_q, busy_q, err_q;
  logic          emit_q, emit_last_q;
  logic [PW-1:0] first_q, pad_val_c, v_c;
  logic [WW-1:0] win_q, win_d, out_win_q;
  logic          out_valid_q, out_last_q;

  logic          img_pos_c, slot_ok_c, last_img_c, final_c;
  logic          emit_c, emit_last_c, last_acc_c;

  logic [PW-1:0] lb_q [K-1][LB_DEPTH];

  // Live configuration, clamped and pre-decoded into scan-grid bounds for capture.
  assign cfg_w_c  = (32'(i_cfg_width) > MAX_IMG_WIDTH) ? 16'(MAX_IMG_WIDTH) : i_cfg_width;
  assign stride_c = (i_cfg_stride == 2'd0) ? 2'd1 : i_cfg_stride;
  assign x_lo_c   = i_cfg_pad_en ? XW'(PAD) : '0;
  assign x_hi_c   = x_lo_c + XW'(cfg_w_c) - XW'(1);
  assign x_max_c  = x_hi_c + x_lo_c;
  assign y_lo_c   = i_cfg_pad_en ? YW'(PAD) : '0;
  assign y_hi_c   = y_lo_c + YW'(i_cfg_height) - YW'(1);
  assign y_max_c  = y_hi_c + y_lo_c;
  assign total_c  = 32'(cfg_w_c) * 32'(i_cfg_height);
  assign degen_c  = !i_cfg_pad_en && ((cfg_w_c < 16'(K)) || (i_cfg_height < 16'(K)));

`ifdef WINGEN_PAD_VALUE_EN
  logic [PW-1:0] pad_val_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pad_val_q <= '0;
    else if (capture_c) pad_val_q <= i_cfg_pad_value;
  end
  assign pad_val_c = pad_val_q;
`else
  assign pad_val_c = '0;
`endif

  assign img_pos_c  = (x_q >= x_lo_q) && (x_q <= x_hi_q) && (y_q >= y_lo_q) && (y_q <= y_hi_q);
  assign slot_ok_c  = !out_valid_q || i_ready;
  assign last_img_c = (x_q == x_hi_q) && (y_q == y_hi_q);
  assign final_c    = (x_q == x_max_q) && (y_q == y_max_q);
  assign last_acc_c = out_valid_q && out_last_q && i_ready;
  assign v_c        = !img_pos_c ? pad_val_c : (first_vld_q ? first_q : i_data);

  assign emit_c = step_c && (x_q >= XW'(K - 1)) && (y_q >= YW'(K - 1)) &&
                  (x_ph_q == 2'd0) && (y_ph_q == 2'd0);
  // No further emission column/row fits in the grid after this one.
  assign emit_last_c = ((XW+2)'(x_q) + (XW+2)'(stride_q) > (XW+2)'(x_max_q)) &&
                       ((YW+2)'(y_q) + (YW+2)'(stride_q) > (YW+2)'(y_max_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ready_c   = 1'b0;
    step_c    = 1'b0;
    capture_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (i_valid) begin
          capture_c = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        ready_c = img_pos_c && slot_ok_c && !first_vld_q;
        step_c  = slot_ok_c && (!img_pos_c || first_vld_q || i_valid);
        if (step_c && final_c)                        state_d = S_DRAIN;
        else if (step_c && img_pos_c && last_img_c)   state_d = S_FLUSH;
      end
      S_FLUSH: begin
        step_c = slot_ok_c;
        if (step_c && final_c) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (degen_q || last_done_q || last_acc_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shift the window left by one column; the new right column is older rows from the line buffers plus the current value.
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[(r*K+c)*PW +: PW] = win_q[(r*K+c+1)*PW +: PW];
      end
    end
    for (int r = 0; r < K - 1; r++) begin
      win_d[(r*K+K-1)*PW +: PW] = lb_q[K-2-r][x_q];
    end
    win_d[((K-1)*K+K-1)*PW +: PW] = v_c;
  end

  always_ff @(posedge clk) begin
    if (step_c) begin
      lb_q[0][x_q] <= v_c;
      for (int i = 1; i < K - 1; i++) lb_q[i][x_q] <= lb_q[i-1][x_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stride_q    <= 2'd1;
      x_lo_q      <= '0;
      x_hi_q      <= '0;
      x_max_q     <= '0;
      y_lo_q      <= '0;
      y_hi_q      <= '0;
      y_max_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      x_ph_q      <= '0;
      y_ph_q      <= '0;
      total_q     <= '0;
      pix_cnt_q   <= '0;
      degen_q     <= 1'b0;
      first_vld_q <= 1'b0;
      first_q     <= '0;
      last_done_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      emit_q      <= 1'b0;
      emit_last_q <= 1'b0;
      win_q       <= '0;
      out_win_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      if (last_acc_c) last_done_q <= 1'b1;

      if (capture_c) begin
        stride_q    <= stride_c;
        x_lo_q      <= x_lo_c;
        x_hi_q      <= x_hi_c;
        x_max_q     <= x_max_c;
        y_lo_q      <= y_lo_c;
        y_hi_q      <= y_hi_c;
        y_max_q     <= y_max_c;
        total_q     <= total_c;
        degen_q     <= degen_c;
        x_q         <= '0;
        y_q         <= '0;
        x_ph_q      <= '0;
        y_ph_q      <= '0;
        first_q     <= i_data;
        first_vld_q <= 1'b1;
        pix_cnt_q   <= 32'd1;
        last_done_q <= 1'b0;
        if (degen_c || (i_tlast != (total_c == 32'd1))) err_q <= 1'b1;
      end

      if ((state_q == S_RUN) && i_valid && ready_c) begin
        pix_cnt_q <= pix_cnt_q + 32'd1;
        if (i_tlast != (pix_cnt_q == total_q - 32'd1)) err_q <= 1'b1;
      end

      if (step_c) begin
        win_q <= win_d;
        if (img_pos_c) first_vld_q <= 1'b0;
        if (final_c) begin
          x_q    <= '0;
          y_q    <= '0;
          x_ph_q <= '0;
          y_ph_q <= '0;
        end else if (x_q == x_max_q) begin
          x_q    <= '0;
          x_ph_q <= '0;
          y_q    <= y_q + YW'(1);
          if (y_q < YW'(K - 1))                      y_ph_q <= '0;
          else if (y_ph_q == 2'(stride_q - 2'd1))    y_ph_q <= '0;
          else                                       y_ph_q <= 2'(y_ph_q + 2'd1);
        end else begin
          x_q <= x_q + XW'(1);
          if (x_q < XW'(K - 1))                      x_ph_q <= '0;
          else if (x_ph_q == 2'(stride_q - 2'd1))    x_ph_q <= '0;
          else                                       x_ph_q <= 2'(x_ph_q + 2'd1);
        end
      end

      // Output slot: pending window moves out whenever the slot is empty or being drained.
      if (slot_ok_c) begin
        out_valid_q <= emit_q;
        out_last_q  <= emit_q && emit_last_q;
        if (emit_q) out_win_q <= win_q;
        emit_q      <= emit_c;
        emit_last_q <= emit_last_c;
      end
    end
  end

  assign o_ready   = ready_c && !rst;
  assign o_valid   = out_valid_q;
  assign o_windows = out_win_q;
  assign o_tlast   = out_last_q;
  assign o_busy    = busy_q;
  assign o_err     = err_q;

endmodule
